// File: rtl/lsq_port_arbiter.sv
// Load/store arbiter for the single data-memory request port, with fence sequencing.
// Optional store-starvation guard enabled by defining LSQ_ARB_STARVE_GUARD_EN.
module lsq_port_arbiter #(
    parameter int unsigned STARVE_LIMIT    = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic             load_conflict,
    output logic             load_pop,
    input  logic             store_valid,
    output logic             store_pop,
    input  logic             sq_empty,
    input  logic             mem_ready,
    output logic             mem_valid,
    output logic             mem_is_store,
    input  logic             store_ack,
    input  logic             fence_req,
    output logic             fence_ack,
    output logic [OUT_W-1:0] outstanding_stores
);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_DRAIN,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fence_ack_nxt;
    logic [OUT_W-1:0] outstanding_nxt;

    logic load_ok;
    logic store_ok;
    logic force_store;
    logic grant_store;
    logic grant_load;

`ifdef LSQ_ARB_STARVE_GUARD_EN
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [AGE_W-1:0] age;

    // Cycles the oldest store has been ready without being popped; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (store_pop || !store_valid) begin
            age <= '0;
        end else if (age < AGE_W'(STARVE_LIMIT)) begin
            age <= age + AGE_W'(1);
        end
    end

    assign force_store = (age >= AGE_W'(STARVE_LIMIT));
`else
    assign force_store = 1'b0;
`endif

    // Same-cycle grant selection; loads only compete while in NORMAL.
    always_comb begin
        grant_store = 1'b0;
        grant_load  = 1'b0;
        load_ok     = load_valid && !load_conflict && (state == ST_NORMAL);
        store_ok    = store_valid && (outstanding_stores < OUT_W'(MAX_OUTSTANDING));
        case (state)
            ST_NORMAL: begin
                grant_store = store_ok && (!load_ok || force_store);
                grant_load  = load_ok && !grant_store;
            end
            ST_DRAIN: begin
                grant_store = store_ok;
            end
            default: begin
                grant_store = 1'b0;
                grant_load  = 1'b0;
            end
        endcase
    end

    // Request outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        mem_valid    = rst && (grant_store || grant_load);
        mem_is_store = rst && grant_store;
        load_pop     = rst && grant_load && mem_ready;
        store_pop    = rst && grant_store && mem_ready;
    end

    // Fence sequencer: block loads, drain the queue, wait for acks, then acknowledge.
    always_comb begin
        state_nxt     = state;
        fence_ack_nxt = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (fence_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sq_empty && !store_pop) begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if ((outstanding_stores == '0) ||
                    ((outstanding_stores == OUT_W'(1)) && store_ack)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_NORMAL;
            end
            default: begin
                state_nxt = ST_NORMAL;
            end
        endcase
        fence_ack_nxt = (state_nxt == ST_DONE);
    end

    // In-flight store count; a pop and an ack in the same cycle cancel.
    always_comb begin
        outstanding_nxt = outstanding_stores;
        case ({store_pop, store_ack})
            2'b10: outstanding_nxt = outstanding_stores + OUT_W'(1);
            2'b01: begin
                if (outstanding_stores != '0) begin
                    outstanding_nxt = outstanding_stores - OUT_W'(1);
                end
            end
            default: outstanding_nxt = outstanding_stores;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_NORMAL;
            fence_ack          <= 1'b0;
            outstanding_stores <= '0;
        end else begin
            state              <= state_nxt;
            fence_ack          <= fence_ack_nxt;
            outstanding_stores <= outstanding_nxt;
        end
    end

    param_range: assert property (@(posedge clk)
        (STARVE_LIMIT >= 1) && (MAX_OUTSTANDING >= 1));

    ack_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        store_ack |-> (outstanding_stores != '0));

    inflight_capped: assert property (@(posedge clk) disable iff (!rst)
        outstanding_stores <= OUT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_lsq_port_arbiter.sv
// Self-checking bench for lsq_port_arbiter: cycle model plus directed scenarios.
// Honours LSQ_ARB_STARVE_GUARD_EN the same way as the design.
module tb_lsq_port_arbiter;

    localparam int unsigned STARVE = 8;
    localparam int unsigned MAXO   = 4;
    localparam int unsigned OW     = $clog2(MAXO + 1);

    logic          clk;
    logic          rst;
    logic          load_valid;
    logic          load_conflict;
    logic          load_pop;
    logic          store_valid;
    logic          store_pop;
    logic          sq_empty;
    logic          mem_ready;
    logic          mem_valid;
    logic          mem_is_store;
    logic          store_ack;
    logic          fence_req;
    logic          fence_ack;
    logic [OW-1:0] outstanding_stores;

    lsq_port_arbiter #(
        .STARVE_LIMIT    (STARVE),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .load_valid         (load_valid),
        .load_conflict      (load_conflict),
        .load_pop           (load_pop),
        .store_valid        (store_valid),
        .store_pop          (store_pop),
        .sq_empty           (sq_empty),
        .mem_ready          (mem_ready),
        .mem_valid          (mem_valid),
        .mem_is_store       (mem_is_store),
        .store_ack          (store_ack),
        .fence_req          (fence_req),
        .fence_ack          (fence_ack),
        .outstanding_stores (outstanding_stores)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: mode 0=normal 1=drain 2=wait-for-acks 3=done
    int m_mode = 0;
    int m_age  = 0;
    int m_out  = 0;
    int sq_cnt = 0;
    int cnt_lp = 0;
    int cnt_sp = 0;
    int cnt_fa = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate the arbitration rules for this cycle, compare, then advance the model.
    task automatic model_cycle();
        int lok, sok, guard, gs, gl, e_lp, e_sp;
        if (!rst) begin
            chk("rst_mem_valid", int'(mem_valid), 0);
            chk("rst_load_pop", int'(load_pop), 0);
            chk("rst_store_pop", int'(store_pop), 0);
            chk("rst_fence_ack", int'(fence_ack), 0);
            chk("rst_outstanding", int'(outstanding_stores), 0);
            m_mode = 0;
            m_age  = 0;
            m_out  = 0;
            return;
        end
        lok = (load_valid && !load_conflict && m_mode == 0) ? 1 : 0;
        sok = (store_valid && m_out < int'(MAXO)) ? 1 : 0;
`ifdef LSQ_ARB_STARVE_GUARD_EN
        guard = (m_age >= int'(STARVE)) ? 1 : 0;
`else
        guard = 0;
`endif
        gs = 0;
        gl = 0;
        if (m_mode == 0) begin
            gs = (sok != 0 && (lok == 0 || guard != 0)) ? 1 : 0;
            gl = (gs == 0 && lok != 0) ? 1 : 0;
        end else if (m_mode == 1) begin
            gs = sok;
        end
        e_lp = (gl != 0 && mem_ready) ? 1 : 0;
        e_sp = (gs != 0 && mem_ready) ? 1 : 0;

        chk("mem_valid", int'(mem_valid), (gs | gl));
        chk("mem_is_store", int'(mem_is_store), gs);
        chk("load_pop", int'(load_pop), e_lp);
        chk("store_pop", int'(store_pop), e_sp);
        chk("fence_ack", int'(fence_ack), (m_mode == 3) ? 1 : 0);
        chk("outstanding", int'(outstanding_stores), m_out);

        cnt_lp += int'(load_pop);
        cnt_sp += int'(store_pop);
        cnt_fa += int'(fence_ack);

        if (e_sp != 0 || !store_valid) m_age = 0;
        else if (m_age < int'(STARVE)) m_age++;

        case (m_mode)
            0: if (fence_req) m_mode = 1;
            1: if (sq_empty && e_sp == 0) m_mode = 2;
            2: if (m_out == 0 || (m_out == 1 && store_ack)) m_mode = 3;
            default: m_mode = 0;
        endcase

        m_out  = m_out + e_sp - int'(store_ack);
        sq_cnt = sq_cnt - e_sp;
    endtask

    // Apply one cycle of inputs (called at posedge+1), check at negedge, return at posedge+1.
    task automatic drive(input bit lv, input bit lc, input bit mr, input bit ack, input bit fr);
        load_valid    = lv;
        load_conflict = lc;
        mem_ready     = mr;
        store_ack     = ack;
        fence_req     = fr;
        store_valid   = (sq_cnt > 0);
        sq_empty      = (sq_cnt == 0);
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lp_at_store;
        int lat;
        int sp_before;
        bit ack;

        rst = 1'b0;
        load_valid = 1'b0; load_conflict = 1'b0; store_valid = 1'b0; sq_empty = 1'b1;
        mem_ready = 1'b0; store_ack = 1'b0; fence_req = 1'b0;

        // Reset held with a requesting load: outputs must stay low
        repeat (2) drive(1, 0, 1, 0, 0);
        chk("reset_outstanding_lit", int'(outstanding_stores), 0);
        rst = 1'b1;

        // Store-only stream
        sq_cnt = 3; cnt_sp = 0;
        repeat (3) drive(0, 0, 1, 0, 0);
        chk("stream_pops_lit", cnt_sp, 3);
        chk("stream_out_lit", int'(outstanding_stores), 3);
        repeat (3) drive(0, 0, 1, 1, 0);
        chk("stream_drained_lit", int'(outstanding_stores), 0);

        // Outstanding cap
        sq_cnt = 5; cnt_sp = 0;
        repeat (6) drive(0, 0, 1, 0, 0);
        chk("cap_pops_lit", cnt_sp, 4);
        chk("cap_held_valid_lit", int'(mem_valid), 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        chk("cap_fifth_lit", cnt_sp, 5);
        repeat (4) drive(0, 0, 1, 1, 0);

        // Loads and one store competing continuously
        sq_cnt = 1; cnt_lp = 0; cnt_sp = 0; lp_at_store = -1;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 1, 0, 0);
            if (cnt_sp > 0 && lp_at_store < 0) lp_at_store = cnt_lp;
        end
`ifdef LSQ_ARB_STARVE_GUARD_EN
        chk("starve_loads_before_store_lit", lp_at_store, 8);
`else
        chk("strict_no_store_lit", cnt_sp, 0);
`endif
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);

        // Conflicting load yields to store, then wins once conflict clears
        sq_cnt = 1; cnt_lp = 0; cnt_sp = 0;
        drive(1, 1, 1, 0, 0);
        chk("conflict_store_lit", cnt_sp, 1);
        chk("conflict_noload_lit", cnt_lp, 0);
        drive(1, 0, 1, 0, 0);
        chk("conflict_load_after_lit", cnt_lp, 1);
        drive(0, 0, 1, 1, 0);

        // Mixed traffic including mem_ready stalls
        for (int i = 0; i < 60; i++) begin
            if (sq_cnt == 0 && ($urandom % 3) == 0) sq_cnt = $urandom_range(1, 3);
            ack = (m_out > 0) && (($urandom % 2) == 1);
            drive(1'($urandom), 1'($urandom), 1'($urandom), ack, 0);
        end
        for (int i = 0; i < 40 && (sq_cnt > 0 || m_out > 0); i++) begin
            drive(0, 0, 1, (m_out > 0), 0);
        end

        // Fence with nothing pending: minimum latency
        cnt_fa = 0; lat = -1;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, (lat < 0));
            if (cnt_fa > 0 && lat < 0) lat = i;
        end
        chk("fence_min_latency_lit", lat, 3);
        chk("fence_min_pulses_lit", cnt_fa, 1);

        // Fence with 2 queued stores and 1 in flight while a load waits
        sq_cnt = 3;
        drive(0, 0, 1, 0, 0);
        cnt_lp = 0; cnt_sp = 0; cnt_fa = 0;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && cnt_fa == 0; i++) begin
            drive(1, 0, 1, (m_mode == 2 && m_out > 0), 1);
        end
        chk("fence_store_pops_lit", cnt_sp, 2);
        chk("fence_no_load_lit", cnt_lp, 0);
        chk("fence_ack_pulses_lit", cnt_fa, 1);
        drive(1, 0, 1, 0, 0);
        chk("fence_load_resume_lit", cnt_lp, 1);
        drive(1, 0, 1, 0, 0);
        chk("fence_single_pulse_lit", cnt_fa, 1);

        // Reset while waiting for store acks
        sq_cnt = 1;
        drive(0, 0, 1, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 1);
        chk("pre_reset_out_lit", int'(outstanding_stores), 1);
        rst = 1'b0;
        load_valid = 1'b1;
        fence_req = 1'b0;
        #1;
        chk("async_rst_mem_valid_lit", int'(mem_valid), 0);
        chk("async_rst_load_pop_lit", int'(load_pop), 0);
        chk("async_rst_out_lit", int'(outstanding_stores), 0);
        chk("async_rst_fence_ack_lit", int'(fence_ack), 0);
        drive(1, 0, 1, 0, 0);
        rst = 1'b1;
        cnt_fa = 0; cnt_lp = 0;
        repeat (4) drive(1, 0, 1, 0, 0);
        chk("post_reset_no_ack_lit", cnt_fa, 0);
        chk("post_reset_loads_lit", cnt_lp, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
